pda_fetch_stage: RTL and testbench

//  Instruction-fetch stage at the head of the PDA pipeline. Drives the PC into a

---
 rtl/pda_fetch_stage.sv | 179 +++++++++++++++++
 tb/tb_pda_fetch_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pda_fetch_stage.sv
// rtl/pda_fetch_stage.sv - PDA pipeline instruction-fetch stage with IF/ID register
//
// Purpose:
//   Issues the PC to a synchronous instruction memory (1-cycle read latency)
//   and captures each returned word into the IF/ID register for decode.
//   Handles decode stall (hold + re-read of the in-flight word), execute-stage
//   branch redirect (squash) and halt draining through a RUN/DRAIN/HALTED FSM.
//
// Optional feature macro: PDA_FETCH_PERF_EN
//   When defined, adds output fetch_count, a saturating count of cycles in
//   which inst_valid is written to 1.
//
// Ports:
//   clk           in   single clock, all state on posedge
//   reset         in   synchronous, active-low
//   halt          in   level request to stop fetching
//   stall         in   decode hazard: hold IF/ID register and PC
//   branch_taken  in   redirect request from execute
//   branch_target in   redirect PC
//   imem_addr     out  instruction-memory read address (combinational)
//   imem_rdata    in   memory data for the address issued the previous cycle
//   pc            out  next address to issue
//   inst          out  IF/ID instruction
//   inst_pc       out  PC of inst
//   inst_valid    out  inst is a real instruction
//   halted        out  fetch is in the HALTED state
//   fetch_count   out  (PDA_FETCH_PERF_EN only) delivered-instruction counter

module pda_fetch_stage #(
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4,
  parameter logic [DATA_W-1:0] NOP_INST = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_target,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] inst,
  output logic [DATA_W-1:0] inst_pc,
  output logic              inst_valid,
  output logic              halted
`ifdef PDA_FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_count
`endif
);

  localparam logic [DATA_W-1:0] PC_INC = DATA_W'(PC_STEP);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Address issued last cycle and whether it was a real fetch.
  logic [DATA_W-1:0] req_pc;
  logic              req_valid;

  // A new valid fetch is issued only in RUN without a pending halt request;
  // the halt cycle itself already stops issuing so the drain has at most one
  // word in flight.
  logic issue;
  // The pipeline advances this cycle (no redirect, no stall).
  logic advance;

  always_comb begin
    issue   = (state == ST_RUN) && !halt;
    advance = !branch_taken && !stall;
  end

  // While stalled the in-flight address is re-issued, so its word is still on
  // imem_rdata in the cycle the stall is released.
  always_comb begin
    imem_addr = stall ? req_pc : pc;
  end

  always_comb begin
    halted = (state == ST_HALTED);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. Only non-stalled, non-redirect cycles move the FSM; a
  // branch redirects the PC but leaves the run/halt status untouched.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    if (advance) begin
      case (state)
        ST_RUN: begin
          if (halt) begin
            state_next = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Completes even if halt has already dropped.
          state_next = ST_HALTED;
        end
        ST_HALTED: begin
          if (!halt) begin
            state_next = ST_RUN;
          end
        end
        default: begin
          state_next = ST_RUN;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // PC, request tracking and IF/ID register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc         <= RESET_PC;
      req_pc     <= RESET_PC;
      req_valid  <= 1'b0;
      inst       <= NOP_INST;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else if (branch_taken) begin
      // Squash both the in-flight word and the IF/ID entry; wins over stall.
      pc         <= branch_target;
      req_valid  <= 1'b0;
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
    end else if (!stall) begin
      inst       <= req_valid ? imem_rdata : NOP_INST;
      inst_pc    <= req_pc;
      inst_valid <= req_valid;
      req_pc     <= pc;
      req_valid  <= issue;
      if (issue) begin
        pc <= pc + PC_INC; // wraps modulo 2^DATA_W
      end
    end
  end

`ifdef PDA_FETCH_PERF_EN
  // ---------------------------------------------------------------------------
  // Delivered-instruction counter, saturating at all-ones.
  // ---------------------------------------------------------------------------
  logic inst_load;

  always_comb begin
    inst_load = advance && req_valid;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_count <= '0;
    end else if (inst_load && (fetch_count != 32'hFFFF_FFFF)) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pda_fetch_stage.sv
// tb/tb_pda_fetch_stage.sv - directed self-checking bench for pda_fetch_stage

module tb_pda_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        halt;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;

  logic [31:0] imem_addr, imem_rdata, pc, inst, inst_pc;
  logic        inst_valid, halted;
  logic [31:0] w_imem_addr, w_imem_rdata, w_pc, w_inst, w_inst_pc;
  logic        w_inst_valid, w_halted;
`ifdef PDA_FETCH_PERF_EN
  logic [31:0] fetch_count, w_fetch_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pda_fetch_stage u_dut (
    .clk(clk), .reset(reset), .halt(halt), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .halted(halted)
`ifdef PDA_FETCH_PERF_EN
    , .fetch_count(fetch_count)
`endif
  );

  pda_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .reset(reset), .halt(halt), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata), .pc(w_pc),
    .inst(w_inst), .inst_pc(w_inst_pc), .inst_valid(w_inst_valid), .halted(w_halted)
`ifdef PDA_FETCH_PERF_EN
    , .fetch_count(w_fetch_count)
`endif
  );

  // Synchronous memories with 1-cycle latency: mem[a] = a | 32'hA000.
  always @(posedge clk) begin
    imem_rdata   <= imem_addr | 32'hA000;
    w_imem_rdata <= w_imem_addr | 32'hA000;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_inst_pc"}, inst_pc, 32'h0);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_imem_addr"}, imem_addr, 32'h0);
  endtask

  initial begin
    logic [31:0] e;
    reset = 1'b0; halt = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;

    // ---- reset state ----
    step();
    step();
    chk_reset_vals("rst");
    chk("rst_wrap_pc", w_pc, 32'hFFFF_FFF8);
`ifdef PDA_FETCH_PERF_EN
    chk("rst_count", fetch_count, 32'd0);
`endif

    // ---- test 1: free run, latency; wrap instance runs alongside ----
    reset = 1'b1;
    step();
    chk("t1_first_valid", 32'(inst_valid), 32'd0);
    chk("t1_first_pc", pc, 32'h4);
    for (int k = 0; k < 6; k++) begin
      step();
      e = 32'(4 * k);
      chk("t1_inst_pc", inst_pc, e);
      chk("t1_inst", inst, e | 32'hA000);
      chk("t1_valid", 32'(inst_valid), 32'd1);
      e = 32'hFFFF_FFF8 + 32'(4 * k);
      chk("t5_wrap_inst_pc", w_inst_pc, e);
      chk("t5_wrap_valid", 32'(w_inst_valid), 32'd1);
    end
`ifdef PDA_FETCH_PERF_EN
    chk("t1_count", fetch_count, 32'd6);
`endif

    // ---- test 2: stall for 3 cycles while inst_pc=8 ----
    do_reset();
    repeat (4) step();
    chk("t2_pre_inst_pc", inst_pc, 32'h8);
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      chk("t2_hold_inst_pc", inst_pc, 32'h8);
      chk("t2_hold_inst", inst, 32'hA008);
      chk("t2_hold_pc", pc, 32'h10);
      chk("t2_hold_addr", imem_addr, 32'hC);
    end
    stall = 1'b0;
    step();
    chk("t2_rel_inst_pc", inst_pc, 32'hC);
    chk("t2_rel_inst", inst, 32'hA00C);
    chk("t2_rel_valid", 32'(inst_valid), 32'd1);
    step();
    chk("t2_next_inst_pc", inst_pc, 32'h10);
    chk("t2_next_valid", 32'(inst_valid), 32'd1);

    // ---- test 3: branch redirect, then branch under stall ----
    do_reset();
    repeat (3) step();
    chk("t3_pre_inst_pc", inst_pc, 32'h4);
    branch_taken = 1'b1; branch_target = 32'h100;
    step();
    branch_taken = 1'b0;
    chk("t3_br_valid", 32'(inst_valid), 32'd0);
    chk("t3_br_inst", inst, 32'h0);
    chk("t3_br_pc", pc, 32'h100);
    step();
    chk("t3_bubble_valid", 32'(inst_valid), 32'd0);
    step();
    chk("t3_tgt_inst_pc", inst_pc, 32'h100);
    chk("t3_tgt_inst", inst, 32'hA100);
    chk("t3_tgt_valid", 32'(inst_valid), 32'd1);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
    step();
    stall = 1'b0; branch_taken = 1'b0;
    chk("t3_sbr_pc", pc, 32'h200);
    chk("t3_sbr_valid", 32'(inst_valid), 32'd0);
    step();
    chk("t3_sbr_bubble", 32'(inst_valid), 32'd0);
    step();
    chk("t3_sbr_inst_pc", inst_pc, 32'h200);
    chk("t3_sbr_inst", inst, 32'hA200);
    chk("t3_sbr_valid2", 32'(inst_valid), 32'd1);

    // ---- test 4: halt drain and resume ----
    do_reset();
    repeat (4) step();
    chk("t4_pre_pc", pc, 32'h10);
    halt = 1'b1;
    step();
    chk("t4_drain_inst_pc", inst_pc, 32'hC);
    chk("t4_drain_valid", 32'(inst_valid), 32'd1);
    chk("t4_drain_pc", pc, 32'h10);
    chk("t4_drain_halted", 32'(halted), 32'd0);
    step();
    chk("t4_halt_valid", 32'(inst_valid), 32'd0);
    chk("t4_halt_halted", 32'(halted), 32'd1);
    step();
    chk("t4_hold_halted", 32'(halted), 32'd1);
    chk("t4_hold_pc", pc, 32'h10);
    halt = 1'b0;
    step();
    chk("t4_resume_halted", 32'(halted), 32'd0);
    chk("t4_resume_valid", 32'(inst_valid), 32'd0);
    step();
    chk("t4_resume_bubble", 32'(inst_valid), 32'd0);
    step();
    chk("t4_resume_inst_pc", inst_pc, 32'h10);
    chk("t4_resume_inst_valid", 32'(inst_valid), 32'd1);
    // halt dropped while in DRAIN still reaches HALTED before running again
    halt = 1'b1;
    step();
    chk("t4b_drain_inst_pc", inst_pc, 32'h14);
    halt = 1'b0;
    step();
    chk("t4b_halted", 32'(halted), 32'd1);
    step();
    chk("t4b_run", 32'(halted), 32'd0);
    step();
    step();
    chk("t4b_inst_pc", inst_pc, 32'h18);
    chk("t4b_valid", 32'(inst_valid), 32'd1);

    // ---- test 6: reset mid-stall and mid-drain ----
    do_reset();
    repeat (4) step();
    stall = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk_reset_vals("t6_stall");
`ifdef PDA_FETCH_PERF_EN
    chk("t6_stall_count", fetch_count, 32'd0);
`endif
    reset = 1'b1; stall = 1'b0;
    repeat (4) step();
    halt = 1'b1;
    step();
    reset = 1'b0;
    step();
    stall = 1'b0;
    chk_reset_vals("t6_drain");
`ifdef PDA_FETCH_PERF_EN
    chk("t6_drain_count", fetch_count, 32'd0);
`endif
    reset = 1'b1; halt = 1'b0;
    step();
    chk("t6_after_pc", pc, 32'h4);
    chk("t6_after_valid", 32'(inst_valid), 32'd0);
    step();
    chk("t6_after_inst_pc", inst_pc, 32'h0);
    chk("t6_after_inst", inst, 32'hA000);
    chk("t6_after_valid2", 32'(inst_valid), 32'd1);
`ifdef PDA_FETCH_PERF_EN
    chk("t6_count1", fetch_count, 32'd1);
`endif
    step();
    chk("t6_after_inst_pc2", inst_pc, 32'h4);
`ifdef PDA_FETCH_PERF_EN
    chk("t6_count2", fetch_count, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
